// File: rtl/trex_pkg.sv
// trex_pkg: dino state enum, sprite-select codes and Q-format helpers
// shared by the jump controller and the sprite draw block.
package trex_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_DUCK,
    ST_RISE,
    ST_FALL,
    ST_DEAD
  } dino_st_e;

  localparam logic [3:0] SEL_RUN0  = 4'd0;
  localparam logic [3:0] SEL_RUN1  = 4'd1;
  localparam logic [3:0] SEL_DUCK0 = 4'd2;
  localparam logic [3:0] SEL_DUCK1 = 4'd3;
  localparam logic [3:0] SEL_JUMP  = 4'd4;
  localparam logic [3:0] SEL_DEAD  = 4'd5;

  localparam int Q_YW   = 10;
  localparam int Q_FRAC = 4;

  // Largest magnitude a signed Q(yw).(frac) value may hold.
  function automatic int q_max(input int yw, input int frac);
    return (2 ** (yw + frac - 1)) - 1;
  endfunction

  // Whole rows to Q-format LSBs.
  function automatic int q_of(input int rows, input int frac);
    return rows * (2 ** frac);
  endfunction

endpackage

// File: rtl/dino_anim_div.sv
// dino_anim_div: frame divider for the run/duck animation phase.
// Ports: clk, rst_n, en (count this frame), clr (restart), ph (phase).
module dino_anim_div #(
  parameter int DIV = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic ph
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ph_q, ph_d;

  always_comb begin
    cnt_d = cnt_q;
    ph_d  = ph_q;
    if (clr) begin
      cnt_d = '0;
      ph_d  = 1'b0;
    end else if (en) begin
      if (cnt_q == CW'(DIV - 1)) begin
        cnt_d = '0;
        ph_d  = ~ph_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ph_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
    end
  end

  assign ph = ph_q;

endmodule

// File: rtl/dino_jump_ctrl.sv
// dino_jump_ctrl: per-frame dino vertical physics, jump/duck/death FSM
// and sprite select. In: jump/duck/hit/restart/ground_y. Out: x/y/sel/flags.
module dino_jump_ctrl
  import trex_pkg::*;
#(
  parameter int YW       = Q_YW,
  parameter int FRAC     = Q_FRAC,
  parameter int X_POS    = 50,
  parameter int V_INIT   = -30,
  parameter int G        = 16,
  parameter int G_HOLD   = 8,
  parameter int G_FAST   = 48,
  parameter int HOLD_MAX = 12,
  parameter int MIN_Y    = 0,
  parameter int ANIM_DIV = 6
) (
  input  logic          FrameClk,
  input  logic          rst_n,
  input  logic          jump,
  input  logic          duck,
  input  logic          hit,
  input  logic          restart,
  input  logic [YW-1:0] ground_y,
  output logic [31:0]   dino_x,
  output logic [31:0]   dino_y,
  output logic [3:0]    dino_sel,
  output logic          airborne,
  output logic          dead
);

  localparam int PW     = YW + FRAC;
  localparam int AW     = PW + 2;
  localparam int HW     = $clog2(HOLD_MAX + 1);
  localparam int VMAX_I = q_max(YW, FRAC);
  localparam int VI_RAW = q_of(V_INIT, FRAC);
  localparam int VI_I   = (VI_RAW < -VMAX_I) ? -VMAX_I : VI_RAW;

  localparam logic signed [AW-1:0] VMAX  = AW'(VMAX_I);
  localparam logic signed [AW-1:0] ZERO  = '0;
  localparam logic signed [PW-1:0] VINIT = PW'(VI_I);
  localparam logic        [PW-1:0] MIN_P = PW'(q_of(MIN_Y, FRAC));
  localparam logic signed [AW-1:0] MIN_Q = $signed({2'b00, MIN_P});

  dino_st_e               state_q, state_d;
  logic        [PW-1:0] pos_q, pos_d;
  logic signed [PW-1:0] vel_q, vel_d;
  logic        [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic                 hold_en_q, hold_en_d;
  logic                 lock_q, lock_d;
  logic                 seed_q, seed_d;

  logic        [PW-1:0] gnd_p;
  logic        [PW-1:0] pos_b;
  logic signed [AW-1:0] gnd_a;
  logic signed [AW-1:0] pos_nx;
  logic signed [AW-1:0] vel_sum;
  logic signed [AW-1:0] vel_new;
  logic signed [AW-1:0] g_add;
  logic                 hold_on;
  logic                 is_dead, kill, grnd, air;
  logic                 anim_clr;
  logic                 anim_ph;

  // pos_q is only loaded on the first edge after reset; until then the
  // ground row stands in for it, avoiding an async load from an input.
  assign gnd_p  = {ground_y, {FRAC{1'b0}}};
  assign pos_b  = seed_q ? pos_q : gnd_p;
  assign gnd_a  = $signed({2'b00, gnd_p});
  assign pos_nx = $signed({2'b00, pos_b})
                + $signed({{2{vel_q[PW-1]}}, vel_q});
  assign seed_d = 1'b1;

  assign hold_on = (state_q == ST_RISE) && jump && hold_en_q
                && (hold_cnt_q < HW'(HOLD_MAX));

  always_comb begin
    g_add = AW'(G);
    if (hold_on) begin
      g_add = AW'(G_HOLD);
    end else if (duck) begin
      g_add = AW'(G_FAST);
    end
  end

  assign vel_sum = $signed({{2{vel_q[PW-1]}}, vel_q}) + g_add;
  assign vel_new = (vel_sum > VMAX) ? VMAX : vel_sum;

  assign is_dead = (state_q == ST_DEAD);
  assign kill    = hit && !is_dead;
  assign grnd    = !kill && ((state_q == ST_RUN) || (state_q == ST_DUCK));
  assign air     = !kill && ((state_q == ST_RISE) || (state_q == ST_FALL));

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_b;
    vel_d      = vel_q;
    hold_cnt_d = hold_cnt_q;
    hold_en_d  = hold_en_q;
    lock_d     = lock_q;
    anim_clr   = 1'b0;
    unique case (1'b1)
      kill: begin
        state_d = ST_DEAD;
      end
      is_dead: begin
        if (restart && !hit) begin
          state_d    = ST_RUN;
          pos_d      = gnd_p;
          vel_d      = '0;
          hold_cnt_d = '0;
          hold_en_d  = 1'b0;
          lock_d     = 1'b0;
          anim_clr   = 1'b1;
        end
      end
      grnd: begin
        pos_d = gnd_p;
        vel_d = '0;
        if (jump && !lock_q) begin
          state_d    = ST_RISE;
          vel_d      = VINIT;
          hold_cnt_d = '0;
          hold_en_d  = 1'b1;
        end else begin
          state_d = duck ? ST_DUCK : ST_RUN;
        end
        // A jump held through landing re-arms only once released.
        if (!jump) begin
          lock_d = 1'b0;
        end
      end
      air: begin
        if (hold_on) begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
        if (!jump) begin
          hold_en_d = 1'b0;
        end
        if (pos_nx >= gnd_a) begin
          state_d    = duck ? ST_DUCK : ST_RUN;
          pos_d      = gnd_p;
          vel_d      = '0;
          hold_cnt_d = '0;
          hold_en_d  = 1'b0;
          lock_d     = jump;
        end else if (pos_nx < MIN_Q) begin
          state_d = ST_FALL;
          pos_d   = MIN_P;
          vel_d   = '0;
        end else begin
          pos_d = pos_nx[PW-1:0];
          vel_d = vel_new[PW-1:0];
          if ((state_q == ST_RISE) && (vel_new >= ZERO)) begin
            state_d = ST_FALL;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge FrameClk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pos_q      <= '0;
      vel_q      <= '0;
      hold_cnt_q <= '0;
      hold_en_q  <= 1'b0;
      lock_q     <= 1'b0;
      seed_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      vel_q      <= vel_d;
      hold_cnt_q <= hold_cnt_d;
      hold_en_q  <= hold_en_d;
      lock_q     <= lock_d;
      seed_q     <= seed_d;
    end
  end

  dino_anim_div #(
    .DIV (ANIM_DIV)
  ) u_anim (
    .clk   (FrameClk),
    .rst_n (rst_n),
    .en    (grnd),
    .clr   (anim_clr),
    .ph    (anim_ph)
  );

  always_comb begin
    dino_sel = SEL_RUN0;
    unique case (state_q)
      ST_RUN:  dino_sel = anim_ph ? SEL_RUN1 : SEL_RUN0;
      ST_DUCK: dino_sel = anim_ph ? SEL_DUCK1 : SEL_DUCK0;
      ST_RISE: dino_sel = SEL_JUMP;
      ST_FALL: dino_sel = SEL_JUMP;
      ST_DEAD: dino_sel = SEL_DEAD;
      default: dino_sel = SEL_RUN0;
    endcase
  end

  assign dino_x   = 32'(X_POS);
  assign dino_y   = {{(32-YW){1'b0}}, pos_b[PW-1:FRAC]};
  assign airborne = (state_q == ST_RISE) || (state_q == ST_FALL);
  assign dead     = is_dead;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// tb_dino_jump_ctrl: scenario tasks plus a randomized run against a
// row/velocity reference model, for V_INIT=-30 and V_INIT=-10 instances.
module tb_dino_jump_ctrl;

  localparam int S_RUN  = 0;
  localparam int S_DUCK = 1;
  localparam int S_RISE = 2;
  localparam int S_FALL = 3;
  localparam int S_DEAD = 4;

  logic        clk;
  logic        rst_n;
  logic        jump, duck, hit, restart;
  logic [9:0]  ground_y;
  logic [31:0] x0, y0, x1, y1;
  logic [3:0]  sel0, sel1;
  logic        air0, dead0, air1, dead1;

  int errs;
  int checks;

  int vinit [2];
  int m_st  [2];
  int m_pos [2];
  int m_vel [2];
  int m_hc  [2];
  int m_he  [2];
  int m_lk  [2];
  int m_ac  [2];
  int m_ap  [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dino_jump_ctrl dut0 (
    .FrameClk (clk),
    .rst_n    (rst_n),
    .jump     (jump),
    .duck     (duck),
    .hit      (hit),
    .restart  (restart),
    .ground_y (ground_y),
    .dino_x   (x0),
    .dino_y   (y0),
    .dino_sel (sel0),
    .airborne (air0),
    .dead     (dead0)
  );

  dino_jump_ctrl #(
    .V_INIT (-10)
  ) dut1 (
    .FrameClk (clk),
    .rst_n    (rst_n),
    .jump     (jump),
    .duck     (duck),
    .hit      (hit),
    .restart  (restart),
    .ground_y (ground_y),
    .dino_x   (x1),
    .dino_y   (y1),
    .dino_sel (sel1),
    .airborne (air1),
    .dead     (dead1)
  );

  task automatic m_reset(input int g);
    for (int k = 0; k < 2; k++) begin
      m_st[k]  = S_RUN;
      m_pos[k] = g * 16;
      m_vel[k] = 0;
      m_hc[k]  = 0;
      m_he[k]  = 0;
      m_lk[k]  = 0;
      m_ac[k]  = 0;
      m_ap[k]  = 0;
    end
  endtask

  // One frame of game physics, positions and speeds in 1/16 rows.
  task automatic model_step(input bit j, d, h, r, input int g);
    int gq, acc, nx, nv;
    bit hold;
    gq = g * 16;
    for (int k = 0; k < 2; k++) begin
      if (h && m_st[k] != S_DEAD) begin
        m_st[k] = S_DEAD;
      end else if (m_st[k] == S_DEAD) begin
        if (r && !h) begin
          m_st[k] = S_RUN; m_pos[k] = gq; m_vel[k] = 0;
          m_hc[k] = 0; m_he[k] = 0; m_lk[k] = 0;
          m_ac[k] = 0; m_ap[k] = 0;
        end
      end else if (m_st[k] == S_RUN || m_st[k] == S_DUCK) begin
        m_ac[k]++;
        if (m_ac[k] == 6) begin
          m_ac[k] = 0;
          m_ap[k] = 1 - m_ap[k];
        end
        m_pos[k] = gq;
        m_vel[k] = 0;
        if (j && m_lk[k] == 0) begin
          m_st[k] = S_RISE; m_vel[k] = vinit[k] * 16;
          m_hc[k] = 0; m_he[k] = 1;
        end else begin
          m_st[k] = d ? S_DUCK : S_RUN;
        end
        if (!j) m_lk[k] = 0;
      end else begin
        hold = (m_st[k] == S_RISE) && j && m_he[k] == 1 && m_hc[k] < 12;
        acc = hold ? 8 : (d ? 48 : 16);
        if (hold) m_hc[k]++;
        if (m_st[k] == S_RISE && !j) m_he[k] = 0;
        nx = m_pos[k] + m_vel[k];
        nv = m_vel[k] + acc;
        if (nv > 8191) nv = 8191;
        if (nx >= gq) begin
          m_st[k] = d ? S_DUCK : S_RUN;
          m_pos[k] = gq; m_vel[k] = 0;
          m_hc[k] = 0; m_he[k] = 0; m_lk[k] = j;
        end else if (nx < 0) begin
          m_st[k] = S_FALL; m_pos[k] = 0; m_vel[k] = 0;
        end else begin
          m_pos[k] = nx;
          m_vel[k] = nv;
          if (m_st[k] == S_RISE && nv >= 0) m_st[k] = S_FALL;
        end
      end
    end
  endtask

  function automatic logic [3:0] exp_sel(input int k);
    case (m_st[k])
      S_RUN:  return (m_ap[k] != 0) ? 4'd1 : 4'd0;
      S_DUCK: return (m_ap[k] != 0) ? 4'd3 : 4'd2;
      S_DEAD: return 4'd5;
      default: return 4'd4;
    endcase
  endfunction

  task automatic tick(input bit j, d, h, r, input int g);
    jump = j; duck = d; hit = h; restart = r;
    ground_y = 10'(g);
    @(posedge clk);
    model_step(j, d, h, r, g);
    #1;
  endtask

  task automatic do_reset(input int g);
    rst_n = 1'b0;
    jump = 0; duck = 0; hit = 0; restart = 0;
    ground_y = 10'(g);
    #2;
    m_reset(g);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    jump = 0; duck = 0; hit = 0; restart = 0;
    ground_y = 10'd200;
    #3;
    checks++;
    if (y0 !== 32'd200) begin
      errs++; $display("FAIL reset_y got=%0d want=200", y0);
    end
    checks++;
    if (sel0 !== 4'd0 || air0 !== 1'b0 || dead0 !== 1'b0) begin
      errs++;
      $display("FAIL reset_flags sel=%0d air=%b dead=%b want 0/0/0",
               sel0, air0, dead0);
    end
    checks++;
    if (x0 !== 32'd50 || x1 !== 32'd50) begin
      errs++; $display("FAIL dino_x got=%0d/%0d want=50", x0, x1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_idle;
    logic [3:0] want;
    do_reset(200);
    for (int n = 1; n <= 20; n++) begin
      tick(0, 0, 0, 0, 200);
      want = 4'((n / 6) % 2);
      checks++;
      if (y0 !== 32'd200 || air0 !== 1'b0 || sel0 !== want) begin
        errs++;
        $display("FAIL idle n=%0d y=%0d air=%b sel=%0d want y=200 air=0 sel=%0d",
                 n, y0, air0, sel0, want);
      end
    end
  endtask

  task automatic test_ceiling;
    int land;
    land = -1;
    do_reset(200);
    tick(1, 0, 0, 0, 200);
    for (int e = 1; e <= 60; e++) begin
      tick(0, 0, 0, 0, 200);
      if (e == 1) begin
        checks++;
        if (y0 !== 32'd170) begin
          errs++; $display("FAIL rise_e1 y=%0d want=170", y0);
        end
      end
      if (e == 2) begin
        checks++;
        if (y0 !== 32'd141) begin
          errs++; $display("FAIL rise_e2 y=%0d want=141", y0);
        end
      end
      if (e == 8) begin
        checks++;
        if (y0 !== 32'd0 || sel0 !== 4'd4 || air0 !== 1'b1) begin
          errs++;
          $display("FAIL ceiling y=%0d sel=%0d air=%b want 0/4/1",
                   y0, sel0, air0);
        end
      end
      if (!air0) begin
        land = e;
        break;
      end
    end
    checks++;
    if (land != 29) begin
      errs++; $display("FAIL land_edge got=%0d want=29", land);
    end
    tick(0, 0, 0, 0, 200);
    checks++;
    if (y0 !== 32'd200 || air0 !== 1'b0 || sel0 > 4'd1) begin
      errs++;
      $display("FAIL after_land y=%0d air=%b sel=%0d want 200/0/run",
               y0, air0, sel0);
    end
  endtask

  task automatic test_hold_vs_tap;
    int tap_min, held_min, exp_min;
    bit landed;
    do_reset(200);
    tap_min = 1000;
    landed = 0;
    tick(1, 0, 0, 0, 200);
    for (int e = 0; e < 60 && !landed; e++) begin
      tick(0, 0, 0, 0, 200);
      if (int'(y1) < tap_min) tap_min = int'(y1);
      if (!air1) landed = 1;
    end
    checks++;
    if (!landed || tap_min != 145) begin
      errs++;
      $display("FAIL tap_apex got=%0d landed=%b want=145", tap_min, landed);
    end
    do_reset(200);
    held_min = 1000;
    exp_min = 1000;
    landed = 0;
    for (int e = 0; e < 80 && !landed; e++) begin
      tick(e < 12, 0, 0, 0, 200);
      if (int'(y1) < held_min) held_min = int'(y1);
      if (m_pos[1] / 16 < exp_min) exp_min = m_pos[1] / 16;
      if (e > 0 && !air1) landed = 1;
    end
    checks++;
    if (!landed || held_min >= 145 || held_min != exp_min) begin
      errs++;
      $display("FAIL held_apex got=%0d want=%0d (<145) landed=%b",
               held_min, exp_min, landed);
    end
  endtask

  task automatic test_fast_fall;
    int land;
    land = -1;
    do_reset(200);
    tick(1, 0, 0, 0, 200);
    for (int e = 1; e <= 10; e++) tick(0, 0, 0, 0, 200);
    checks++;
    if (y0 !== 32'd1 || air0 !== 1'b1) begin
      errs++; $display("FAIL pre_duck y=%0d air=%b want 1/1", y0, air0);
    end
    for (int e = 11; e <= 60; e++) begin
      tick(0, 1, 0, 0, 200);
      if (e == 13) begin
        checks++;
        if (y0 !== 32'd16) begin
          errs++; $display("FAIL fast_fall_e13 y=%0d want=16", y0);
        end
      end
      if (!air0) begin
        land = e;
        break;
      end
    end
    checks++;
    if (land != 22 || y0 !== 32'd200 || sel0 !== 4'd2) begin
      errs++;
      $display("FAIL duck_land edge=%0d y=%0d sel=%0d want 22/200/2",
               land, y0, sel0);
    end
  endtask

  task automatic test_hit;
    do_reset(200);
    tick(1, 0, 0, 0, 200);
    for (int e = 0; e < 3; e++) tick(0, 0, 0, 0, 200);
    tick(0, 0, 1, 0, 200);
    checks++;
    if (dead0 !== 1'b1 || y0 !== 32'd113 || sel0 !== 4'd5 || air0 !== 1'b0) begin
      errs++;
      $display("FAIL hit y=%0d dead=%b sel=%0d air=%b want 113/1/5/0",
               y0, dead0, sel0, air0);
    end
    tick(0, 0, 1, 1, 200);
    checks++;
    if (dead0 !== 1'b1 || y0 !== 32'd113) begin
      errs++; $display("FAIL hit_restart dead=%b y=%0d want 1/113", dead0, y0);
    end
    tick(0, 0, 0, 1, 180);
    checks++;
    if (dead0 !== 1'b0 || y0 !== 32'd180 || sel0 !== 4'd0 || air0 !== 1'b0) begin
      errs++;
      $display("FAIL restart y=%0d dead=%b sel=%0d want 180/0/0",
               y0, dead0, sel0);
    end
  endtask

  task automatic test_back_to_back;
    bit seen, landed;
    seen = 0;
    landed = 0;
    do_reset(200);
    for (int e = 0; e < 80 && !landed; e++) begin
      tick(1, 0, 0, 0, 200);
      if (seen && !air1) landed = 1;
      if (air1) seen = 1;
    end
    checks++;
    if (!landed || y1 !== 32'd200) begin
      errs++; $display("FAIL held_land landed=%b y=%0d want 1/200", landed, y1);
    end
    for (int e = 0; e < 3; e++) begin
      tick(1, 0, 0, 0, 200);
      checks++;
      if (air1 !== 1'b0) begin
        errs++; $display("FAIL no_relaunch e=%0d air=%b want=0", e, air1);
      end
    end
    tick(0, 0, 0, 0, 200);
    tick(1, 0, 0, 0, 200);
    checks++;
    if (air1 !== 1'b1) begin
      errs++; $display("FAIL rearm air=%b want=1", air1);
    end
  endtask

  task automatic test_async_reset;
    do_reset(200);
    tick(1, 0, 0, 0, 200);
    for (int e = 0; e < 3; e++) tick(0, 0, 0, 0, 200);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (y0 !== 32'd200 || y1 !== 32'd200 || air0 !== 1'b0 ||
        sel0 !== 4'd0 || dead0 !== 1'b0) begin
      errs++;
      $display("FAIL async_reset y=%0d/%0d air=%b sel=%0d want 200/200/0/0",
               y0, y1, air0, sel0);
    end
    do_reset(200);
    tick(0, 0, 0, 0, 200);
  endtask

  task automatic test_random;
    bit j, d, h, r;
    int g;
    g = 200;
    do_reset(g);
    for (int n = 0; n < 600; n++) begin
      j = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 3) == 0);
      h = ($urandom_range(0, 59) == 0);
      r = ($urandom_range(0, 5) == 0);
      if (n > 0 && $urandom_range(0, 24) == 0) g = $urandom_range(120, 400);
      tick(j, d, h, r, g);
      checks++;
      if (y0 !== 32'(m_pos[0] / 16) || sel0 !== exp_sel(0) ||
          air0 !== (m_st[0] == S_RISE || m_st[0] == S_FALL) ||
          dead0 !== (m_st[0] == S_DEAD)) begin
        errs++;
        $display("FAIL rand0 n=%0d y=%0d sel=%0d air=%b dead=%b want y=%0d sel=%0d st=%0d",
                 n, y0, sel0, air0, dead0, m_pos[0] / 16, exp_sel(0), m_st[0]);
      end
      checks++;
      if (y1 !== 32'(m_pos[1] / 16) || sel1 !== exp_sel(1) ||
          air1 !== (m_st[1] == S_RISE || m_st[1] == S_FALL) ||
          dead1 !== (m_st[1] == S_DEAD)) begin
        errs++;
        $display("FAIL rand1 n=%0d y=%0d sel=%0d air=%b dead=%b want y=%0d sel=%0d st=%0d",
                 n, y1, sel1, air1, dead1, m_pos[1] / 16, exp_sel(1), m_st[1]);
      end
    end
  endtask

  initial begin
    errs = 0;
    checks = 0;
    vinit[0] = -30;
    vinit[1] = -10;
    m_reset(200);
    test_reset;
    test_idle;
    test_ceiling;
    test_hold_vs_tap;
    test_fast_fall;
    test_hit;
    test_back_to_back;
    test_async_reset;
    test_random;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
